// File: rtl/srng_api.sv
// srng entropy buffer: host register bus in front of a word FIFO that is filled by the entropy source.
// Optional repetition-count health test on incoming words is enabled by defining SRNG_API_HEALTH_EN.
module srng_api #(
   parameter int          DEPTH_LOG2        = 3,
   parameter logic [31:0] DEF_NUM_DIGESTS   = 32'h00000004,
   parameter logic [31:0] DEF_SAMPLE_CYCLES = 32'h00001000
`ifdef SRNG_API_HEALTH_EN
   ,
   parameter int          REP_LIMIT         = 4
`endif
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        we,
   input  logic [7:0]  address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   input  logic        ent_valid,
   input  logic [31:0] ent_data,
   output logic        ent_ready,
   output logic [31:0] num_digests,
   output logic [31:0] num_sample_cycles
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [7:0] ADDR_NAME0   = 8'h00;
   localparam logic [7:0] ADDR_NAME1   = 8'h01;
   localparam logic [7:0] ADDR_VERSION = 8'h02;
   localparam logic [7:0] ADDR_CTRL    = 8'h08;
   localparam logic [7:0] ADDR_STATUS  = 8'h09;
   localparam logic [7:0] ADDR_DIGESTS = 8'h0a;
   localparam logic [7:0] ADDR_SAMPLES = 8'h0b;
   localparam logic [7:0] ADDR_DATA    = 8'h10;

   localparam logic [31:0] NAME0   = 32'h73726e67;
   localparam logic [31:0] NAME1   = 32'h20617069;
   localparam logic [31:0] VERSION = 32'h00000001;

   localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  enable;
   logic                  error;

   logic bus_rd;
   logic bus_wr;
   logic ctrl_wr;
   logic flush;
   logic clear_err;
   logic data_rd;
   logic empty;
   logic full;
   logic pop;
   logic underflow;
   logic accept;
   logic push;
   logic trip;

   assign bus_rd    = cs && !we;
   assign bus_wr    = cs && we;
   assign ctrl_wr   = bus_wr && (address == ADDR_CTRL);
   assign flush     = ctrl_wr && write_data[2];
   assign clear_err = ctrl_wr && write_data[1];
   assign data_rd   = bus_rd && (address == ADDR_DATA);

   assign empty     = (count == '0);
   assign full      = (count == FULL_COUNT);
   assign pop       = data_rd && !empty;
   assign underflow = data_rd && empty;

   // A flush write blocks the source so no word lands in a FIFO being cleared.
   assign ent_ready = enable && !full && !flush;
   assign accept    = ent_valid && ent_ready;
   assign push      = accept && !trip;

`ifdef SRNG_API_HEALTH_EN
   localparam int REP_W = $clog2(REP_LIMIT + 1);

   logic [REP_W-1:0] rep_cnt;
   logic [REP_W-1:0] rep_next;
   logic [31:0]      last_word;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      rep_next = REP_W'(1);
      if ((rep_cnt != '0) && (ent_data == last_word)) begin
         // Saturate so a long stuck run keeps tripping instead of wrapping.
         rep_next = (rep_cnt == REP_W'(REP_LIMIT)) ? rep_cnt : rep_cnt + 1'b1;
      end
   end

   assign trip = accept && (rep_next >= REP_W'(REP_LIMIT));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rep_cnt   <= '0;
         last_word <= '0;
      end else if (flush) begin
         rep_cnt   <= '0;
      end else if (accept) begin
         rep_cnt   <= rep_next;
         last_word <= ent_data;
      end
   end
`else
   assign trip = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; stale words are unreachable once the pointers and count clear.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ent_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable            <= 1'b1;
         error             <= 1'b0;
         num_digests       <= DEF_NUM_DIGESTS;
         num_sample_cycles <= DEF_SAMPLE_CYCLES;
      end else begin
         if (ctrl_wr) enable <= write_data[0];
         // Setting wins over a same-cycle clear so no fault is lost.
         if (underflow || trip) begin
            error <= 1'b1;
         end else if (clear_err) begin
            error <= 1'b0;
         end
         if (bus_wr && (address == ADDR_DIGESTS)) num_digests       <= write_data;
         if (bus_wr && (address == ADDR_SAMPLES)) num_sample_cycles <= write_data;
      end
   end

   always_comb begin
      read_data = '0;
      if (cs) begin
         case (address)
            ADDR_NAME0:   read_data = NAME0;
            ADDR_NAME1:   read_data = NAME1;
            ADDR_VERSION: read_data = VERSION;
            ADDR_CTRL:    read_data = {31'h0, enable};
            ADDR_STATUS:  read_data = {16'h0, 8'(count), 6'h0, error, !empty};
            ADDR_DIGESTS: read_data = num_digests;
            ADDR_SAMPLES: read_data = num_sample_cycles;
            ADDR_DATA:    read_data = empty ? 32'h0 : mem[rd_ptr];
            default:      read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_srng_api.sv
// Directed bench for srng_api: register map, FIFO ordering via a scoreboard queue, full/empty/flush corners.
// Health-test expectations follow SRNG_API_HEALTH_EN, matching the build of the design.
module tb_srng_api;

   localparam logic [7:0] A_NAME0   = 8'h00;
   localparam logic [7:0] A_NAME1   = 8'h01;
   localparam logic [7:0] A_VERSION = 8'h02;
   localparam logic [7:0] A_CTRL    = 8'h08;
   localparam logic [7:0] A_STATUS  = 8'h09;
   localparam logic [7:0] A_DIGESTS = 8'h0a;
   localparam logic [7:0] A_SAMPLES = 8'h0b;
   localparam logic [7:0] A_DATA    = 8'h10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cs;
   logic        we;
   logic [7:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ent_valid;
   logic [31:0] ent_data;
   logic        ent_ready;
   logic [31:0] num_digests;
   logic [31:0] num_sample_cycles;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb[$];

`ifdef SRNG_API_HEALTH_EN
   localparam int REP_LIMIT = 4;
   int          rep_run  = 0;
   logic [31:0] rep_last = '0;
`endif

   logic [31:0] d;
   logic [31:0] exp_word;
   logic        rdy;
   logic        stall;
   int          idx;
   int          n_left;

   srng_api dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .cs                (cs),
      .we                (we),
      .address           (address),
      .write_data        (write_data),
      .read_data         (read_data),
      .ent_valid         (ent_valid),
      .ent_data          (ent_data),
      .ent_ready         (ent_ready),
      .num_digests       (num_digests),
      .num_sample_cycles (num_sample_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] status_exp(input int cnt, input logic err);
      return {16'h0, 8'(cnt), 6'h0, err, (cnt != 0)};
   endfunction

   // Scoreboard entry for a word the DUT accepted; the health model decides whether it is stored.
   task automatic model_accept(input logic [31:0] w);
`ifdef SRNG_API_HEALTH_EN
      if (rep_run != 0 && w == rep_last) rep_run = (rep_run >= REP_LIMIT) ? REP_LIMIT : rep_run + 1;
      else rep_run = 1;
      rep_last = w;
      if (rep_run < REP_LIMIT) sb.push_back(w);
`else
      sb.push_back(w);
`endif
   endtask

   task automatic model_flush();
      sb.delete();
`ifdef SRNG_API_HEALTH_EN
      rep_run = 0;
`endif
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [31:0] data);
      @(negedge clk);
      cs = 1'b1; we = 1'b0; address = a;
      #2 data = read_data;
      @(posedge clk);
      #1 cs = 1'b0; address = '0;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] wd);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; address = a; write_data = wd;
      @(posedge clk);
      #1 cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
   endtask

   task automatic push_word(input logic [31:0] w);
      logic r;
      @(negedge clk);
      ent_valid = 1'b1; ent_data = w;
      #2 r = ent_ready;
      @(posedge clk);
      if (r) model_accept(w);
      #1 ent_valid = 1'b0;
      check("push_ready", {31'h0, r}, 32'h1);
   endtask

   task automatic pop_check(input string tag);
      logic [31:0] got;
      logic [31:0] want;
      bus_read(A_DATA, got);
      want = (sb.size() != 0) ? sb.pop_front() : 32'h0;
      check(tag, got, want);
   endtask

   initial begin
      cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
      ent_valid = 1'b0; ent_data = '0; reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #2;
      check("rst_ent_ready", {31'h0, ent_ready}, 32'h1);
      check("rst_num_digests", num_digests, 32'h00000004);
      check("rst_num_samples", num_sample_cycles, 32'h00001000);
      check("rst_read_idle", read_data, 32'h0);

      bus_read(A_NAME0, d);   check("name0", d, 32'h73726e67);
      bus_read(A_NAME1, d);   check("name1", d, 32'h20617069);
      bus_read(A_VERSION, d); check("version", d, 32'h00000001);
      bus_read(A_STATUS, d);  check("rst_status", d, 32'h0);
      bus_read(A_CTRL, d);    check("rst_ctrl", d, 32'h1);

      // A word pushed this cycle must not yet show in STATUS (no bypass).
      @(negedge clk);
      ent_valid = 1'b1; ent_data = 32'hdeadbeef;
      cs = 1'b1; we = 1'b0; address = A_STATUS;
      #2 check("nobypass_status", read_data, 32'h0);
      rdy = ent_ready;
      @(posedge clk);
      if (rdy) model_accept(32'hdeadbeef);
      #1 ent_valid = 1'b0; cs = 1'b0; address = '0;
      bus_read(A_STATUS, d); check("one_word_status", d, 32'h00000101);
      pop_check("one_word_data");
      bus_read(A_STATUS, d); check("one_word_drained", d, 32'h0);

      // Hold ent_valid high until the FIFO fills; bounded cycle budget.
      idx = 0; stall = 1'b0;
      @(negedge clk);
      ent_valid = 1'b1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         ent_data = 32'hc0de0000 + 32'(idx);
         #2;
         if (!ent_ready) begin
            stall = 1'b1;
            break;
         end
         @(posedge clk);
         model_accept(ent_data);
         idx++;
         @(negedge clk);
      end
      check("fill_accepted", 32'(idx), 32'd8);
      check("fill_stalled", {31'h0, stall}, 32'h1);
      // Pop while full: ready stays low this cycle, rises the next.
      cs = 1'b1; we = 1'b0; address = A_DATA;
      #1;
      check("full_pop_ready", {31'h0, ent_ready}, 32'h0);
      exp_word = (sb.size() != 0) ? sb.pop_front() : 32'h0;
      check("full_pop_data", read_data, exp_word);
      @(posedge clk);
      #1 cs = 1'b0; address = '0;
      @(negedge clk);
      #2 check("reraise_ready", {31'h0, ent_ready}, 32'h1);
      rdy = ent_ready;
      @(posedge clk);
      if (rdy) model_accept(ent_data);
      #1 ent_valid = 1'b0;
      bus_read(A_STATUS, d); check("full_status", d, status_exp(8, 1'b0));
      for (int i = 0; i < 8; i++) pop_check("drain_order");

      bus_read(A_DATA, d);   check("underflow_data", d, 32'h0);
      bus_read(A_STATUS, d); check("underflow_status", d, status_exp(0, 1'b1));

      bus_write(A_CTRL, 32'h0);
      @(negedge clk);
      #2 check("disabled_ready", {31'h0, ent_ready}, 32'h0);
      bus_read(A_CTRL, d);   check("ctrl_disabled", d, 32'h0);
      bus_read(A_STATUS, d); check("error_sticky", d, status_exp(0, 1'b1));
      bus_write(A_CTRL, 32'h1);

      push_word(32'h11111111);
      push_word(32'h22222222);
      // Simultaneous push and pop on a non-empty FIFO.
      @(negedge clk);
      ent_valid = 1'b1; ent_data = 32'h33333333;
      cs = 1'b1; we = 1'b0; address = A_DATA;
      #2 exp_word = (sb.size() != 0) ? sb.pop_front() : 32'h0;
      check("pushpop_data", read_data, exp_word);
      rdy = ent_ready;
      @(posedge clk);
      if (rdy) model_accept(32'h33333333);
      #1 ent_valid = 1'b0; cs = 1'b0; address = '0;
      bus_read(A_STATUS, d); check("pushpop_status", d, status_exp(2, 1'b1));
      push_word(32'h44444444);
      bus_read(A_STATUS, d); check("three_queued", d, status_exp(3, 1'b1));

      bus_write(A_DIGESTS, 32'h10);
      bus_write(A_SAMPLES, 32'h2000);
      check("num_digests_port", num_digests, 32'h10);
      check("num_samples_port", num_sample_cycles, 32'h2000);
      bus_read(A_DIGESTS, d); check("num_digests_rd", d, 32'h10);
      bus_read(A_SAMPLES, d); check("num_samples_rd", d, 32'h2000);

      // Flush write with a word offered in the same cycle: word refused, FIFO cleared, error kept.
      @(negedge clk);
      cs = 1'b1; we = 1'b1; address = A_CTRL; write_data = 32'h5;
      ent_valid = 1'b1; ent_data = 32'h55555555;
      #2 check("flush_ready", {31'h0, ent_ready}, 32'h0);
      @(posedge clk);
      #1 cs = 1'b0; we = 1'b0; address = '0; write_data = '0; ent_valid = 1'b0;
      model_flush();
      bus_read(A_STATUS, d); check("flush_status", d, status_exp(0, 1'b1));
      bus_read(A_CTRL, d);   check("flush_ctrl", d, 32'h1);
      bus_write(A_CTRL, 32'h3);
      bus_read(A_STATUS, d); check("clear_error", d, 32'h0);

      bus_write(8'h20, 32'hffffffff);
      bus_read(8'h20, d);    check("unmapped_rd", d, 32'h0);
      bus_read(A_STATUS, d); check("unmapped_noeffect", d, 32'h0);

      repeat (4) push_word(32'h5a5a5a5a);
      bus_read(A_STATUS, d);
`ifdef SRNG_API_HEALTH_EN
      check("health_status", d, status_exp(3, 1'b1));
`else
      check("health_status", d, status_exp(4, 1'b0));
`endif
      n_left = sb.size();
      for (int i = 0; i < n_left; i++) pop_check("health_drain");
      bus_write(A_CTRL, 32'h3);
      bus_read(A_STATUS, d); check("health_cleared", d, 32'h0);

      // Asynchronous reset in the middle of a cycle with a word queued.
      push_word(32'h12345678);
      @(negedge clk);
      #1 reset_n = 1'b0;
      cs = 1'b1; we = 1'b0; address = A_STATUS;
      #1 check("midreset_status", read_data, 32'h0);
      check("midreset_ready", {31'h0, ent_ready}, 32'h1);
      check("midreset_digests", num_digests, 32'h00000004);
      cs = 1'b0; address = '0;
      model_flush();
      @(negedge clk);
      reset_n = 1'b1;
      bus_read(A_DATA, d); check("postreset_data", d, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
